// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer_if : control/target inputs and PC/RAS status of pc_sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic             pc_write;
  logic [2:0]       pc_source;
  logic             zero;
  logic             neg;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] reg_target;
  logic             exception;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] epc;
  logic             taken;
  logic [CW-1:0]    ras_count;
  logic             ras_overflow;
  logic             ras_underflow;
  logic             ras_mismatch;

  modport master (
    output pc_write, pc_source, zero, neg, branch_target, jump_target,
           reg_target, exception, eret,
    input  pc, pc_plus4, epc, taken, ras_count, ras_overflow,
           ras_underflow, ras_mismatch
  );

  modport slave (
    input  pc_write, pc_source, zero, neg, branch_target, jump_target,
           reg_target, exception, eret,
    output pc, pc_plus4, epc, taken, ras_count, ras_overflow,
           ras_underflow, ras_mismatch
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer : next-PC selection with traps and a circular return-address stack
// Revision 1.0
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('hFC)
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  localparam logic [2:0] SRC_SEQ = 3'd0;
  localparam logic [2:0] SRC_BEQ = 3'd1;
  localparam logic [2:0] SRC_BNE = 3'd2;
  localparam logic [2:0] SRC_BLT = 3'd3;
  localparam logic [2:0] SRC_BGE = 3'd4;
  localparam logic [2:0] SRC_J   = 3'd5;
  localparam logic [2:0] SRC_JAL = 3'd6;
  localparam logic [2:0] SRC_JR  = 3'd7;

  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pc_plus4, sel_target;
  logic             taken_q, taken_d, mis_q, mis_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, sel_taken, ras_we;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_q, top_d, pop_idx;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  always_comb begin
    pc_plus4 = pc_q + WIDTH'(4);
    sel_taken  = 1'b0;
    sel_target = bus.branch_target;
    case (bus.pc_source)
      SRC_SEQ: sel_taken = 1'b0;
      SRC_BEQ: sel_taken = bus.zero;
      SRC_BNE: sel_taken = ~bus.zero;
      SRC_BLT: sel_taken = bus.neg;
      SRC_BGE: sel_taken = ~bus.neg;
      SRC_J, SRC_JAL: begin
        sel_taken  = 1'b1;
        sel_target = bus.jump_target;
      end
      default: begin
        sel_taken  = 1'b1;
        sel_target = bus.reg_target;
      end
    endcase
  end

  // top_q points at the next free slot; when full it is also the oldest entry
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    taken_d = 1'b0;
    mis_d   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    ras_we  = 1'b0;
    pop_idx = (top_q == '0) ? LAST : top_q - 1'b1;
    if (bus.exception) begin
      epc_d   = pc_q;
      pc_d    = EXC_VECTOR;
      taken_d = 1'b1;
    end else if (bus.eret) begin
      pc_d    = epc_q;
      taken_d = 1'b1;
    end else if (bus.pc_write) begin
      pc_d    = sel_taken ? sel_target : pc_plus4;
      taken_d = sel_taken;
      if (bus.pc_source == SRC_JAL) begin
        ras_we = 1'b1;
        top_d  = (top_q == LAST) ? '0 : top_q + 1'b1;
        if (cnt_q == FULL) ovf_d = 1'b1;
        else               cnt_d = cnt_q + 1'b1;
      end else if (bus.pc_source == SRC_JR) begin
        if (cnt_q == '0) begin
          unf_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          top_d = pop_idx;
          mis_d = (ras_mem_q[pop_idx] != bus.reg_target);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cnt_q   <= '0;
      top_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
    end
  end

  // Stack storage needs no reset: entries beyond cnt_q are never read
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem_q[top_q] <= pc_plus4;
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.epc           = epc_q;
  assign bus.taken         = taken_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
  assign bus.ras_mismatch  = mis_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_sequencer : directed and randomized checks of pc_sequencer against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(4)) bus_a ();
  pc_sequencer_if #(.WIDTH(8),  .RAS_DEPTH(4)) bus_b ();
  pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(2)) bus_c ();

  pc_sequencer #(.WIDTH(32), .RAS_DEPTH(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'hFC))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  pc_sequencer #(.WIDTH(8), .RAS_DEPTH(4), .RESET_VECTOR(8'h0), .EXC_VECTOR(8'hFC))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  pc_sequencer #(.WIDTH(32), .RAS_DEPTH(2), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'hFC))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Reference model of instance A (RAS_DEPTH 4): newest return address at the back
  logic [31:0] m_pc, m_epc;
  logic        m_taken, m_mis, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_taken = 0; m_mis = 0; m_ovf = 0; m_unf = 0;
    m_ras.delete();
  endtask

  // Advance one clock; the model evaluates instance A's current inputs
  task automatic tick();
    logic [31:0] p4, npc, nepc, e;
    logic        nt, nmis;
    logic [2:0]  src;
    src = bus_a.pc_source;
    p4 = m_pc + 32'd4; npc = m_pc; nepc = m_epc; nt = 0; nmis = 0;
    if (bus_a.exception) begin
      nepc = m_pc; npc = 32'hFC; nt = 1;
    end else if (bus_a.eret) begin
      npc = m_epc; nt = 1;
    end else if (bus_a.pc_write) begin
      case (src)
        3'd0: nt = 0;
        3'd1: nt = bus_a.zero;
        3'd2: nt = !bus_a.zero;
        3'd3: nt = bus_a.neg;
        3'd4: nt = !bus_a.neg;
        default: nt = 1;
      endcase
      if (!nt)                        npc = p4;
      else if (src == 5 || src == 6)  npc = bus_a.jump_target;
      else if (src == 7)              npc = bus_a.reg_target;
      else                            npc = bus_a.branch_target;
      if (src == 6) begin
        if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_ovf = 1; end
        m_ras.push_back(p4);
      end
      if (src == 7) begin
        if (m_ras.size() == 0) m_unf = 1;
        else begin e = m_ras.pop_back(); nmis = (e != bus_a.reg_target); end
      end
    end
    @(posedge clk); #1;
    m_pc = npc; m_epc = nepc; m_taken = nt; m_mis = nmis;
  endtask

  task automatic set_a(input logic w, input logic [2:0] src);
    bus_a.pc_write = w; bus_a.pc_source = src;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    checks++; if (bus_a.pc !== 32'h0)       begin errors++; $display("FAIL reset_pc got %h want 0", bus_a.pc); end
    checks++; if (bus_a.epc !== 32'h0)      begin errors++; $display("FAIL reset_epc got %h want 0", bus_a.epc); end
    checks++; if (bus_a.taken !== 1'b0)     begin errors++; $display("FAIL reset_taken got %b want 0", bus_a.taken); end
    checks++; if (bus_a.ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus_a.ras_count); end
    checks++; if ({bus_a.ras_overflow, bus_a.ras_underflow, bus_a.ras_mismatch} !== 3'b000)
      begin errors++; $display("FAIL reset_flags got %b want 000", {bus_a.ras_overflow, bus_a.ras_underflow, bus_a.ras_mismatch}); end
    checks++; if (bus_b.pc !== 8'h0)        begin errors++; $display("FAIL reset_pc_b got %h want 0", bus_b.pc); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    set_a(1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus_a.pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d got %h want %h", i, bus_a.pc, exp_pc[i]); end
      checks++; if (bus_a.taken !== 1'b0)   begin errors++; $display("FAIL seq_taken%0d got %b want 0", i, bus_a.taken); end
    end
  endtask

  task automatic test_branch();
    set_a(1, 3'd5); bus_a.jump_target = 32'h10; tick();
    checks++; if (bus_a.pc !== 32'h10) begin errors++; $display("FAIL j_pc got %h want 10", bus_a.pc); end
    set_a(1, 3'd1); bus_a.zero = 1; bus_a.branch_target = 32'h40; tick();
    checks++; if (bus_a.pc !== 32'h40) begin errors++; $display("FAIL beq_pc got %h want 40", bus_a.pc); end
    checks++; if (bus_a.taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b want 1", bus_a.taken); end
    set_a(0, 3'd1); tick();
    checks++; if (bus_a.taken !== 1'b0) begin errors++; $display("FAIL taken_pulse got %b want 0", bus_a.taken); end
    checks++; if (bus_a.pc !== 32'h40) begin errors++; $display("FAIL stall_pc got %h want 40", bus_a.pc); end
    set_a(1, 3'd2); tick();
    checks++; if (bus_a.pc !== 32'h44) begin errors++; $display("FAIL bne_pc got %h want 44", bus_a.pc); end
    checks++; if (bus_a.taken !== 1'b0) begin errors++; $display("FAIL bne_taken got %b want 0", bus_a.taken); end
    bus_a.zero = 0;
  endtask

  task automatic test_wrap();
    set_a(0, 3'd0);
    bus_b.pc_write = 1; bus_b.pc_source = 3'd5; bus_b.jump_target = 8'hFC; tick();
    checks++; if (bus_b.pc !== 8'hFC)       begin errors++; $display("FAIL w8_pc got %h want fc", bus_b.pc); end
    checks++; if (bus_b.pc_plus4 !== 8'h00) begin errors++; $display("FAIL w8_plus4 got %h want 00", bus_b.pc_plus4); end
    bus_b.pc_source = 3'd0; tick();
    checks++; if (bus_b.pc !== 8'h00)       begin errors++; $display("FAIL w8_wrap got %h want 00", bus_b.pc); end
    bus_b.pc_write = 0;
  endtask

  task automatic test_ras_overflow();
    bus_c.pc_write = 1; bus_c.pc_source = 3'd6;
    bus_c.jump_target = 32'h100; tick();
    bus_c.jump_target = 32'h200; tick();
    checks++; if (bus_c.ras_count !== 2'd2)   begin errors++; $display("FAIL ras_full got %0d want 2", bus_c.ras_count); end
    checks++; if (bus_c.ras_overflow !== 1'b0) begin errors++; $display("FAIL ras_ovf_early got %b want 0", bus_c.ras_overflow); end
    bus_c.jump_target = 32'h300; tick();
    checks++; if (bus_c.ras_count !== 2'd2)   begin errors++; $display("FAIL ras_ovf_count got %0d want 2", bus_c.ras_count); end
    checks++; if (bus_c.ras_overflow !== 1'b1) begin errors++; $display("FAIL ras_ovf got %b want 1", bus_c.ras_overflow); end
    bus_c.pc_source = 3'd7; bus_c.reg_target = 32'h204; tick();
    checks++; if (bus_c.pc !== 32'h204)       begin errors++; $display("FAIL jr_pc got %h want 204", bus_c.pc); end
    checks++; if (bus_c.ras_mismatch !== 1'b0) begin errors++; $display("FAIL jr_match got %b want 0", bus_c.ras_mismatch); end
    bus_c.reg_target = 32'h999; tick();
    checks++; if (bus_c.ras_mismatch !== 1'b1) begin errors++; $display("FAIL jr_mismatch got %b want 1", bus_c.ras_mismatch); end
    checks++; if (bus_c.ras_count !== 2'd0)   begin errors++; $display("FAIL jr_count got %0d want 0", bus_c.ras_count); end
    bus_c.pc_write = 0; tick();
    checks++; if (bus_c.ras_mismatch !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b want 0", bus_c.ras_mismatch); end
    bus_c.pc_write = 1; tick();
    checks++; if (bus_c.ras_underflow !== 1'b1) begin errors++; $display("FAIL ras_unf got %b want 1", bus_c.ras_underflow); end
    checks++; if (bus_c.ras_mismatch !== 1'b0)  begin errors++; $display("FAIL unf_mis got %b want 0", bus_c.ras_mismatch); end
    checks++; if (bus_c.ras_overflow !== 1'b1)  begin errors++; $display("FAIL ovf_sticky got %b want 1", bus_c.ras_overflow); end
    bus_c.pc_write = 0;
  endtask

  task automatic test_exception();
    set_a(1, 3'd6); bus_a.jump_target = 32'h20; tick();
    checks++; if (bus_a.ras_count !== 3'd1) begin errors++; $display("FAIL jal_count got %0d want 1", bus_a.ras_count); end
    bus_a.exception = 1; bus_a.eret = 1; bus_a.jump_target = 32'h500; tick();
    checks++; if (bus_a.pc !== 32'hFC)      begin errors++; $display("FAIL exc_pc got %h want fc", bus_a.pc); end
    checks++; if (bus_a.epc !== 32'h20)     begin errors++; $display("FAIL exc_epc got %h want 20", bus_a.epc); end
    checks++; if (bus_a.ras_count !== 3'd1) begin errors++; $display("FAIL exc_count got %0d want 1", bus_a.ras_count); end
    checks++; if (bus_a.taken !== 1'b1)     begin errors++; $display("FAIL exc_taken got %b want 1", bus_a.taken); end
    bus_a.exception = 0; set_a(0, 3'd6); tick();
    checks++; if (bus_a.pc !== 32'h20)      begin errors++; $display("FAIL eret_pc got %h want 20", bus_a.pc); end
    checks++; if (bus_a.epc !== 32'h20)     begin errors++; $display("FAIL eret_epc got %h want 20", bus_a.epc); end
    bus_a.eret = 0;
  endtask

  task automatic test_stall_reset();
    set_a(0, 3'd6); bus_a.jump_target = 32'h700;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus_a.pc !== 32'h20)      begin errors++; $display("FAIL stall_pc%0d got %h want 20", i, bus_a.pc); end
      checks++; if (bus_a.ras_count !== 3'd1) begin errors++; $display("FAIL stall_cnt%0d got %0d want 1", i, bus_a.ras_count); end
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (bus_a.pc !== 32'h0)       begin errors++; $display("FAIL async_pc got %h want 0", bus_a.pc); end
    checks++; if (bus_a.ras_count !== 3'd0) begin errors++; $display("FAIL async_cnt got %0d want 0", bus_a.ras_count); end
    checks++; if (bus_a.epc !== 32'h0)      begin errors++; $display("FAIL async_epc got %h want 0", bus_a.epc); end
    @(negedge clk) rst_n = 1'b1;
    set_a(1, 3'd0); tick();
    checks++; if (bus_a.pc !== 32'h4)       begin errors++; $display("FAIL post_reset_pc got %h want 4", bus_a.pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus_a.pc_write      = ($urandom_range(0, 3) != 0);
      bus_a.pc_source     = 3'($urandom_range(0, 7));
      bus_a.zero          = 1'($urandom);
      bus_a.neg           = 1'($urandom);
      bus_a.branch_target = $urandom & 32'hFFFF_FFFC;
      bus_a.jump_target   = $urandom & 32'hFFFF_FFFC;
      bus_a.reg_target    = $urandom & 32'hFFFF_FFFC;
      if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) bus_a.reg_target = m_ras[$];
      if (i % 7 == 3) bus_a.jump_target = 32'hFFFF_FFFC;
      bus_a.exception     = ($urandom_range(0, 15) == 0);
      bus_a.eret          = ($urandom_range(0, 15) == 0);
      tick();
      checks++; if (bus_a.pc !== m_pc)         begin errors++; $display("FAIL rnd_pc@%0d got %h want %h", i, bus_a.pc, m_pc); end
      checks++; if (bus_a.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4@%0d got %h want %h", i, bus_a.pc_plus4, m_pc + 32'd4); end
      checks++; if (bus_a.epc !== m_epc)       begin errors++; $display("FAIL rnd_epc@%0d got %h want %h", i, bus_a.epc, m_epc); end
      checks++; if (bus_a.taken !== m_taken)   begin errors++; $display("FAIL rnd_taken@%0d got %b want %b", i, bus_a.taken, m_taken); end
      checks++; if (bus_a.ras_count !== 3'(m_ras.size())) begin errors++; $display("FAIL rnd_cnt@%0d got %0d want %0d", i, bus_a.ras_count, m_ras.size()); end
      checks++; if ({bus_a.ras_overflow, bus_a.ras_underflow, bus_a.ras_mismatch} !== {m_ovf, m_unf, m_mis})
        begin errors++; $display("FAIL rnd_flags@%0d got %b want %b", i, {bus_a.ras_overflow, bus_a.ras_underflow, bus_a.ras_mismatch}, {m_ovf, m_unf, m_mis}); end
    end
    bus_a.exception = 0; bus_a.eret = 0; bus_a.pc_write = 0;
  endtask

  initial begin
    bus_a.pc_write = 0; bus_a.pc_source = 0; bus_a.zero = 0; bus_a.neg = 0;
    bus_a.branch_target = 0; bus_a.jump_target = 0; bus_a.reg_target = 0;
    bus_a.exception = 0; bus_a.eret = 0;
    bus_b.pc_write = 0; bus_b.pc_source = 0; bus_b.zero = 0; bus_b.neg = 0;
    bus_b.branch_target = 0; bus_b.jump_target = 0; bus_b.reg_target = 0;
    bus_b.exception = 0; bus_b.eret = 0;
    bus_c.pc_write = 0; bus_c.pc_source = 0; bus_c.zero = 0; bus_c.neg = 0;
    bus_c.branch_target = 0; bus_c.jump_target = 0; bus_c.reg_target = 0;
    bus_c.exception = 0; bus_c.eret = 0;
    model_reset();
    test_reset();
    test_seq();
    test_branch();
    test_wrap();
    test_ras_overflow();
    test_exception();
    test_stall_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the PC and target bit width (legal range 8..64).
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, meaning the return-address stack entry count (legal range 1..16).
REQ-003 The block SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded at reset.
REQ-004 The block SHALL have parameter EXC_VECTOR, default 'hFC, meaning the PC value loaded on exception.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 pc_write  in  1  commit enable; 0 = stall, PC and stack hold.
REQ-009 pc_source  in  3  next-PC mode select (see REQ-016).
REQ-010 zero  in  1  ALU result is zero.
REQ-011 neg  in  1  ALU result is negative.
REQ-012 branch_target / jump_target / reg_target  in  WIDTH each  candidate targets.
REQ-013 exception, eret  in  1 each  trap request; return from trap.
REQ-014 pc, pc_plus4, epc  out  WIDTH each  current PC; PC+4; saved exception PC.
REQ-015 taken  out  1; ras_count  out  clog2(RAS_DEPTH+1); ras_overflow  out  1; ras_underflow  out  1; ras_mismatch  out  1.

Function
REQ-016 pc_source SHALL decode as follows; "taken" means the target is used, otherwise pc_plus4 is used.
- 000 SEQ: pc_plus4.
- 001 BEQ: branch_target if zero.
- 010 BNE: branch_target if !zero.
- 011 BLT: branch_target if neg.
- 100 BGE: branch_target if !neg.
- 101 J: jump_target.
- 110 JAL: jump_target; push pc_plus4 onto the RAS.
- 111 JR: reg_target; pop the RAS.
REQ-017 pc_plus4 SHALL be combinational pc+4, truncated to WIDTH (wraps modulo 2^WIDTH).
REQ-018 Per clock edge, priority SHALL be: exception > eret > pc_write > hold.
REQ-019 On exception, the block SHALL load epc<=pc and pc<=EXC_VECTOR, regardless of pc_write and pc_source; the RAS is unchanged.
REQ-020 On eret without exception, the block SHALL load pc<=epc; epc and the RAS are unchanged.
REQ-021 On pc_write=1 without exception or eret, pc SHALL load the REQ-016 selection, with single-cycle latency (new pc visible the cycle after the edge).
REQ-022 With pc_write=0 and no exception or eret, all state SHALL hold.
REQ-023 taken SHALL be a registered, one-cycle pulse, 1 after any edge where pc was loaded with a non-pc_plus4 value (taken branch, J, JAL, JR, exception, eret); otherwise 0.
REQ-024 The RAS SHALL be a circular LIFO of RAS_DEPTH entries, and ras_count SHALL equal the valid entry count.
REQ-025 A push when ras_count=RAS_DEPTH SHALL overwrite the oldest entry, keep ras_count at RAS_DEPTH, and set ras_overflow (sticky).
REQ-026 A pop when ras_count=0 SHALL leave ras_count at 0, set ras_underflow (sticky), and not assert ras_mismatch.
REQ-027 A pop when ras_count>0 SHALL decrement ras_count and pulse ras_mismatch for one cycle (registered) if the popped entry != reg_target; pc always uses reg_target.
REQ-028 Sticky flags SHALL clear only on reset.
REQ-029 Stalled or pre-empted JAL/JR (pc_write=0, exception, or eret) SHALL neither push nor pop.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force pc=RESET_VECTOR, epc=0, taken=0, ras_count=0, ras_overflow=0, ras_underflow=0, ras_mismatch=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard RAS contents; the first commit after rst_n rises SHALL act from RESET_VECTOR.

Verification
REQ-032 Reset then 3 SEQ commits -> pc = 0, 4, 8, 0xC; taken=0 throughout.
REQ-033 pc=0x10, BEQ with zero=1, branch_target=0x40 -> pc=0x40, taken=1 for one cycle; repeat with BNE and zero=1 -> pc=0x44, taken=0.
REQ-034 WIDTH=8, pc=0xFC, SEQ -> pc=0x00 (wrap).
REQ-035 RAS_DEPTH=2: JAL at pc=0x00, 0x100, 0x200 -> ras_count=2, ras_overflow=1; JR reg_target=0x204 -> no mismatch; JR reg_target=0x999 -> ras_mismatch pulse; third JR -> ras_underflow=1.
REQ-036 pc=0x20, exception and eret asserted together with pc_write=1, JAL -> pc=EXC_VECTOR, epc=0x20, ras_count unchanged; next eret -> pc=0x20.
REQ-037 pc_write=0 with JAL for 3 cycles -> pc and ras_count hold; rst_n pulsed low asynchronously between clock edges -> pc=RESET_VECTOR immediately.
